// File: rtl/counter_checker.sv
// Cycle-by-cycle compare of counter DUT outputs against scoreboard expectations, with a
// latency-alignment pipeline, saturating statistics, first-failure capture and a verdict.
module counter_checker #(
  parameter int unsigned LAT   = 0,
  parameter int unsigned ERR_W = 8,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_start,
  input  logic             chk_stop,
  input  logic [3:0]       scb_Q,
  input  logic             scb_rco,
  input  logic             scb_load,
  input  logic [3:0]       C_syn_Q,
  input  logic             C_syn_rco,
  input  logic             C_syn_load,
  output logic             chk_active,
  output logic             chk_done,
  output logic             chk_pass,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] rco_count,
  output logic             err_first_valid,
  output logic [CYC_W-1:0] err_first_cycle,
  output logic [5:0]       err_first_exp,
  output logic [5:0]       err_first_obs
);

  typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

  state_e           state_q;
  logic             active_q, done_q, pass_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [CYC_W-1:0] cyc_cnt_q, rco_cnt_q;
  logic             first_vld_q;
  logic [CYC_W-1:0] first_cyc_q;
  logic [5:0]       first_exp_q, first_obs_q;

  logic [5:0] e_vec, o_vec, e_dly;
  logic       e_dly_vld;
  logic       mismatch;

  assign e_vec = {scb_load, scb_rco, scb_Q};
  assign o_vec = {C_syn_load, C_syn_rco, C_syn_Q};

  generate
    if (LAT == 0) begin : g_direct
      assign e_dly     = e_vec;
      assign e_dly_vld = 1'b1;
    end else begin : g_pipe
      logic [5:0]     pipe_q [LAT];
      logic [LAT-1:0] vld_q;

      // Valids only accumulate on non-entry CHECK edges, so the first compare lands LAT
      // edges after the first sampled expected value.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
          vld_q <= '0;
        end else if (chk_start || (state_q != StCheck)) begin
          vld_q <= '0;
        end else begin
          pipe_q[0] <= e_vec;
          vld_q[0]  <= 1'b1;
          for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
            vld_q[i]  <= vld_q[i-1];
          end
        end
      end

      assign e_dly     = pipe_q[LAT-1];
      assign e_dly_vld = vld_q[LAT-1];
    end
  endgenerate

  // Case inequality so that X/Z on the observed side is flagged in simulation.
  assign mismatch = (e_dly !== o_vec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      rco_cnt_q   <= '0;
      first_vld_q <= 1'b0;
      first_cyc_q <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else if (chk_start) begin
      // Start wins over stop in every state and always opens a fresh window.
      state_q     <= StCheck;
      active_q    <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      rco_cnt_q   <= '0;
      first_vld_q <= 1'b0;
      first_cyc_q <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      case (state_q)
        StCheck: begin
          if (chk_stop) begin
            state_q  <= StDone;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            pass_q   <= (err_cnt_q == '0) && (cyc_cnt_q != '0);
          end else if (e_dly_vld) begin
            if (~&cyc_cnt_q) cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
            if (C_syn_rco && ~&rco_cnt_q) rco_cnt_q <= rco_cnt_q + CYC_W'(1);
            if (mismatch) begin
              if (~&err_cnt_q) err_cnt_q <= err_cnt_q + ERR_W'(1);
              if (!first_vld_q) begin
                first_vld_q <= 1'b1;
                first_cyc_q <= cyc_cnt_q;
                first_exp_q <= e_dly;
                first_obs_q <= o_vec;
              end
            end
          end
        end
        StIdle, StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign chk_active      = active_q;
  assign chk_done        = done_q;
  assign chk_pass        = pass_q;
  assign err_count       = err_cnt_q;
  assign cycle_count     = cyc_cnt_q;
  assign rco_count       = rco_cnt_q;
  assign err_first_valid = first_vld_q;
  assign err_first_cycle = first_cyc_q;
  assign err_first_exp   = first_exp_q;
  assign err_first_obs   = first_obs_q;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench: three checker instances (LAT=0, LAT=2, ERR_W=4) share one stimulus
// stream and are compared against a window-history reference model plus directed vectors.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       chk_start = 1'b0, chk_stop = 1'b0;
  logic [3:0] scb_Q = '0, C_syn_Q = '0;
  logic       scb_rco = 1'b0, scb_load = 1'b0, C_syn_rco = 1'b0, C_syn_load = 1'b0;

  logic        act[3], dn[3], ps[3], fv[3];
  logic [15:0] cy[3], rc[3], fc[3];
  logic [5:0]  fe[3], fo[3];
  logic [7:0]  er0, er1;
  logic [3:0]  er2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_checker #(.LAT(0), .ERR_W(8), .CYC_W(16)) u_lat0 (
    .clk(clk), .reset(reset), .chk_start(chk_start), .chk_stop(chk_stop),
    .scb_Q(scb_Q), .scb_rco(scb_rco), .scb_load(scb_load),
    .C_syn_Q(C_syn_Q), .C_syn_rco(C_syn_rco), .C_syn_load(C_syn_load),
    .chk_active(act[0]), .chk_done(dn[0]), .chk_pass(ps[0]), .err_count(er0),
    .cycle_count(cy[0]), .rco_count(rc[0]), .err_first_valid(fv[0]),
    .err_first_cycle(fc[0]), .err_first_exp(fe[0]), .err_first_obs(fo[0])
  );

  counter_checker #(.LAT(2), .ERR_W(8), .CYC_W(16)) u_lat2 (
    .clk(clk), .reset(reset), .chk_start(chk_start), .chk_stop(chk_stop),
    .scb_Q(scb_Q), .scb_rco(scb_rco), .scb_load(scb_load),
    .C_syn_Q(C_syn_Q), .C_syn_rco(C_syn_rco), .C_syn_load(C_syn_load),
    .chk_active(act[1]), .chk_done(dn[1]), .chk_pass(ps[1]), .err_count(er1),
    .cycle_count(cy[1]), .rco_count(rc[1]), .err_first_valid(fv[1]),
    .err_first_cycle(fc[1]), .err_first_exp(fe[1]), .err_first_obs(fo[1])
  );

  counter_checker #(.LAT(0), .ERR_W(4), .CYC_W(16)) u_err4 (
    .clk(clk), .reset(reset), .chk_start(chk_start), .chk_stop(chk_stop),
    .scb_Q(scb_Q), .scb_rco(scb_rco), .scb_load(scb_load),
    .C_syn_Q(C_syn_Q), .C_syn_rco(C_syn_rco), .C_syn_load(C_syn_load),
    .chk_active(act[2]), .chk_done(dn[2]), .chk_pass(ps[2]), .err_count(er2),
    .cycle_count(cy[2]), .rco_count(rc[2]), .err_first_valid(fv[2]),
    .err_first_cycle(fc[2]), .err_first_exp(fe[2]), .err_first_obs(fo[2])
  );

  // Reference model: window history of expected vectors, compared by index arithmetic.
  int          lat[3]  = '{0, 2, 0};
  int          emax[3] = '{255, 255, 15};
  int          m_mode[3];  // 0 idle, 1 check, 2 done
  int          m_err[3], m_cyc[3], m_rco[3], m_fc[3];
  bit          m_fv[3], m_pass[3];
  logic [5:0]  m_fe[3], m_fo[3];
  logic [5:0]  hist[$];

  task automatic model_clear();
    for (int n = 0; n < 3; n++) begin
      m_err[n] = 0; m_cyc[n] = 0; m_rco[n] = 0; m_fc[n] = 0;
      m_fv[n] = 0; m_pass[n] = 0; m_fe[n] = '0; m_fo[n] = '0;
    end
    hist.delete();
  endtask

  task automatic model_edge(input bit st, input bit sp, input logic [5:0] e, input logic [5:0] o);
    if (st) begin
      model_clear();
      for (int n = 0; n < 3; n++) m_mode[n] = 1;
    end else if (m_mode[0] == 1 && sp) begin
      for (int n = 0; n < 3; n++) begin
        m_mode[n] = 2;
        m_pass[n] = (m_err[n] == 0) && (m_cyc[n] != 0);
      end
    end else if (m_mode[0] == 1) begin
      hist.push_back(e);
      for (int n = 0; n < 3; n++) begin
        int j;
        logic [5:0] ed;
        j = hist.size();
        if (j - 1 >= lat[n]) begin
          ed = hist[j-1-lat[n]];
          if (ed !== o) begin
            if (!m_fv[n]) begin
              m_fv[n] = 1; m_fc[n] = m_cyc[n]; m_fe[n] = ed; m_fo[n] = o;
            end
            if (m_err[n] < emax[n]) m_err[n]++;
          end
          if (m_cyc[n] < 65535) m_cyc[n]++;
          if (o[4] && m_rco[n] < 65535) m_rco[n]++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got=%0h want=%0h", name, n, $time, a, x);
    end
  endtask

  function automatic logic [7:0] err_of(input int n);
    if (n == 0) return er0;
    if (n == 1) return er1;
    return {4'h0, er2};
  endfunction

  task automatic check_all();
    for (int n = 0; n < 3; n++) begin
      chk("active", n, 32'(act[n]), 32'(m_mode[n] == 1));
      chk("done", n, 32'(dn[n]), 32'(m_mode[n] == 2));
      if (m_mode[n] == 2) chk("pass", n, 32'(ps[n]), 32'(m_pass[n]));
      chk("err_count", n, 32'(err_of(n)), 32'(m_err[n]));
      chk("cycle_count", n, 32'(cy[n]), 32'(m_cyc[n]));
      chk("rco_count", n, 32'(rc[n]), 32'(m_rco[n]));
      chk("first_valid", n, 32'(fv[n]), 32'(m_fv[n]));
      chk("first_cycle", n, 32'(fc[n]), 32'(m_fc[n]));
      chk("first_exp", n, 32'(fe[n]), 32'(m_fe[n]));
      chk("first_obs", n, 32'(fo[n]), 32'(m_fo[n]));
    end
  endtask

  task automatic step(input bit st, input bit sp, input logic [5:0] e, input logic [5:0] o);
    chk_start = st; chk_stop = sp;
    {scb_load, scb_rco, scb_Q}       = e;
    {C_syn_load, C_syn_rco, C_syn_Q} = o;
    model_edge(st, sp, e, o);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset between clock edges; outputs must clear before the next edge.
  task automatic mid_reset();
    #2 reset = 1'b0;
    for (int n = 0; n < 3; n++) m_mode[n] = 0;
    model_clear();
    #1;
    check_all();
    for (int n = 0; n < 3; n++) chk("pass_rst", n, 32'(ps[n]), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [5:0] cnt_vec(input int i);
    logic [3:0] q;
    q = 4'(i);
    return {1'b0, (q == 4'hF), q};
  endfunction

  typedef struct {
    bit st; bit sp; logic [3:0] eq; logic [3:0] oq;
    bit act; bit dn; bit ps; int err; int cyc;
  } vec_t;

  vec_t       tbl[10];
  logic [5:0] drv[$];
  logic [5:0] e, o, p1, p2;
  bit         dly_mode;

  initial begin
    tbl[0] = '{1, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 4'h7, 4'h7, 1, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 4'h8, 4'h8, 1, 0, 0, 0, 2};
    tbl[3] = '{0, 0, 4'h9, 4'h9, 1, 0, 0, 0, 3};
    tbl[4] = '{0, 0, 4'hA, 4'hA, 1, 0, 0, 0, 4};
    tbl[5] = '{0, 0, 4'hB, 4'hB, 1, 0, 0, 0, 5};
    tbl[6] = '{0, 0, 4'h2, 4'h3, 1, 0, 0, 1, 6};
    tbl[7] = '{0, 0, 4'hC, 4'hC, 1, 0, 0, 1, 7};
    tbl[8] = '{0, 0, 4'hD, 4'hD, 1, 0, 0, 1, 8};
    tbl[9] = '{0, 1, 4'h0, 4'h0, 0, 1, 0, 1, 8};

    for (int n = 0; n < 3; n++) m_mode[n] = 0;
    model_clear();
    #12;
    check_all();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Stop in IDLE is ignored.
    step(0, 1, 6'h00, 6'h00);

    // LAT=0 identical counting stream, 20 compares, rco once.
    step(1, 0, 6'h00, 6'h00);
    for (int i = 0; i < 20; i++) step(0, 0, cnt_vec(i), cnt_vec(i));
    step(0, 1, 6'h00, 6'h00);
    chk("t1_done", 0, 32'(dn[0]), 32'd1);
    chk("t1_pass", 0, 32'(ps[0]), 32'd1);
    chk("t1_err", 0, 32'(er0), 32'd0);
    chk("t1_cyc", 0, 32'(cy[0]), 32'd20);
    chk("t1_rco", 0, 32'(rc[0]), 32'd1);

    // Single mismatch on the 6th compare, table-driven.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].sp, {2'b00, tbl[i].eq}, {2'b00, tbl[i].oq});
      chk("tbl_active", i, 32'(act[0]), 32'(tbl[i].act));
      chk("tbl_done", i, 32'(dn[0]), 32'(tbl[i].dn));
      if (tbl[i].dn) chk("tbl_pass", i, 32'(ps[0]), 32'(tbl[i].ps));
      chk("tbl_err", i, 32'(er0), 32'(tbl[i].err));
      chk("tbl_cyc", i, 32'(cy[0]), 32'(tbl[i].cyc));
    end
    chk("t2_fv", 0, 32'(fv[0]), 32'd1);
    chk("t2_fcyc", 0, 32'(fc[0]), 32'd5);
    chk("t2_fexp", 0, 32'(fe[0]), 32'h02);
    chk("t2_fobs", 0, 32'(fo[0]), 32'h03);

    // Observed stream lags expected by two: LAT=2 passes with 16 compares, LAT=0 fails.
    drv.delete();
    step(1, 0, 6'h00, 6'h00);
    for (int i = 0; i < 18; i++) begin
      e = cnt_vec(i);
      drv.push_back(e);
      o = (i >= 2) ? drv[i-2] : 6'h00;
      step(0, 0, e, o);
    end
    step(0, 1, 6'h00, 6'h00);
    chk("t3_pass_lat2", 1, 32'(ps[1]), 32'd1);
    chk("t3_cyc_lat2", 1, 32'(cy[1]), 32'd16);
    chk("t3_err_lat0_nz", 0, 32'(er0 != 0), 32'd1);

    // 20 consecutive mismatches: ERR_W=4 saturates at 15, capture keeps the first.
    step(1, 0, 6'h00, 6'h00);
    for (int i = 0; i < 20; i++) step(0, 0, 6'(i + 1), 6'(i + 1) ^ 6'h3F);
    chk("t4_err_sat", 2, 32'(er2), 32'd15);
    chk("t4_fcyc", 2, 32'(fc[2]), 32'd0);
    chk("t4_fexp", 2, 32'(fe[2]), 32'h01);
    chk("t4_fobs", 2, 32'(fo[2]), 32'h3E);
    step(0, 1, 6'h00, 6'h00);

    // Three mismatches then asynchronous reset mid-window.
    step(1, 0, 6'h00, 6'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 6'h05, 6'h06);
    mid_reset();
    chk("t5_act_rst", 0, 32'(act[0]), 32'd0);
    step(0, 1, 6'h00, 6'h00);
    step(1, 1, 6'h00, 6'h00);
    chk("t5_startstop_act", 0, 32'(act[0]), 32'd1);
    chk("t5_startstop_cyc", 0, 32'(cy[0]), 32'd0);

    // Zero-compare window fails.
    step(1, 0, 6'h00, 6'h00);
    step(0, 1, 6'h00, 6'h00);
    chk("t6_done", 0, 32'(dn[0]), 32'd1);
    chk("t6_pass", 0, 32'(ps[0]), 32'd0);
    chk("t6_cyc", 0, 32'(cy[0]), 32'd0);

    // Randomised windows against the model.
    p1 = '0; p2 = '0; dly_mode = 0;
    for (int i = 0; i < 800; i++) begin
      bit st, sp;
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 29) == 0);
      if (st) dly_mode = $urandom_range(0, 1) == 1;
      e = 6'($urandom);
      o = dly_mode ? p2 : e;
      if ($urandom_range(0, 15) == 0) o = 6'($urandom);
      step(st, sp, e, o);
      p2 = p1; p1 = e;
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
